keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/keypad_scan_ctrl.sv | 113 +++++++++++
 tb/tb_keypad_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key code type,
// column one-hot drive patterns and small decode helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   typedef logic [3:0] key_code_t;

   localparam logic [3:0] COL0 = 4'b0001;
   localparam logic [3:0] COL1 = 4'b0010;
   localparam logic [3:0] COL2 = 4'b0100;
   localparam logic [3:0] COL3 = 4'b1000;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] onehot_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // row*4 + column is simply the two 2-bit indices concatenated
   function automatic key_code_t make_key_code(input logic [3:0] row, input logic [3:0] col);
      return {onehot_index(row), onehot_index(col)};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4 keypad row lines (asynchronous active-high reset).
// Only instantiated when KEYPAD_SYNC_EN is defined.
module sync_2ff (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= 4'd0;
         q        <= 4'd0;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce and a one-entry key register.
// Define KEYPAD_SYNC_EN to pass the row lines through a 2-flop synchronizer first.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 27000,
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fila,
   output logic [3:0] columna,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_overrun
);

   localparam int DIV_W = $clog2(SCAN_DIV + 1);
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

   logic [3:0]       row;
   state_t           state_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic [DEB_W-1:0] deb_cnt_reg;
   logic [3:0]       row_lat_reg;
   logic             accept;
   logic             load_key;

`ifdef KEYPAD_SYNC_EN
   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (fila),
      .q   (row)
   );
`else
   assign row = fila;
`endif

   // A full debounce with zero or several rows latched still goes to HOLD, just without a key
   assign accept   = (state_reg == ST_DEBOUNCE) && (deb_cnt_reg == DEB_MAX) && is_onehot(row_lat_reg);
   assign load_key = accept && (!key_valid || key_ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_SCAN;
         columna     <= COL0;
         div_cnt_reg <= '0;
         deb_cnt_reg <= '0;
         row_lat_reg <= 4'd0;
         key_code    <= 4'd0;
         key_valid   <= 1'b0;
         key_overrun <= 1'b0;
      end else begin
         key_overrun <= accept && key_valid && !key_ack;

         if (load_key) begin
            key_code  <= make_key_code(row_lat_reg, columna);
            key_valid <= 1'b1;
         end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
         end

         case (state_reg)
            ST_SCAN: begin
               if (row != 4'd0) begin
                  row_lat_reg <= row;
                  deb_cnt_reg <= '0;
                  state_reg   <= ST_DEBOUNCE;
               end else if (div_cnt_reg == DIV_LAST) begin
                  div_cnt_reg <= '0;
                  columna     <= {columna[2:0], columna[3]};
               end else begin
                  div_cnt_reg <= div_cnt_reg + 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (deb_cnt_reg == DEB_MAX) begin
                  state_reg <= ST_HOLD;
               end else if (row == row_lat_reg) begin
                  deb_cnt_reg <= deb_cnt_reg + 1'b1;
               end else begin
                  // bounce: resume scanning from the same column with a fresh dwell
                  state_reg   <= ST_SCAN;
                  div_cnt_reg <= '0;
               end
            end
            ST_HOLD: begin
               if (row == 4'd0) begin
                  state_reg   <= ST_RELEASE;
                  deb_cnt_reg <= '0;
               end
            end
            ST_RELEASE: begin
               if (row != 4'd0) begin
                  state_reg <= ST_HOLD;
               end else if (deb_cnt_reg == DEB_MAX) begin
                  state_reg   <= ST_SCAN;
                  div_cnt_reg <= '0;
                  columna     <= {columna[2:0], columna[3]};
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed testbench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CYCLES=8, no synchronizer.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fila;
   logic [3:0] columna;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_overrun;

   int checks  = 0;
   int errors  = 0;
   int ovr_cnt = 0;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fila        (fila),
      .columna     (columna),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ack     (key_ack),
      .key_overrun (key_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // advance n clock cycles, ending on a falling edge; tally overrun pulses seen
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         if (key_overrun === 1'b1) ovr_cnt++;
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      fila    = 4'd0;
      key_ack = 1'b0;
      repeat (5) @(negedge clk);
      rst     = 1'b0;
      ovr_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;

      // reset values while rst is held
      rst = 1'b1; fila = 4'd0; key_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_columna", 32'(columna), 32'h1);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_code", 32'(key_code), 32'h0);
      chk("rst_overrun", 32'(key_overrun), 32'h0);

      // idle rotation, 4 cycles per column
      do_reset();
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("idle_col_%0d", k), 32'(columna), 32'd1 << ((k / 4) % 4));
         step(1);
      end

      // row 2 pressed on column 1 -> key 9
      do_reset();
      step(4);
      chk("p1_col_before", 32'(columna), 32'h2);
      fila = 4'b0100;
      step(9);
      chk("p1_valid_early", 32'(key_valid), 32'h0);
      chk("p1_col_frozen", 32'(columna), 32'h2);
      step(1);
      chk("p1_valid", 32'(key_valid), 32'h1);
      chk("p1_code", 32'(key_code), 32'h9);
      step(10);
      chk("p1_valid_hold", 32'(key_valid), 32'h1);
      fila = 4'd0;
      step(9);
      chk("p1_col_release", 32'(columna), 32'h2);
      step(1);
      chk("p1_col_advanced", 32'(columna), 32'h4);
      chk("p1_valid_noack", 32'(key_valid), 32'h1);
      chk("p1_code_kept", 32'(key_code), 32'h9);
      chk("p1_no_overrun", 32'(ovr_cnt), 32'h0);
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      chk("p1_ack_clear", 32'(key_valid), 32'h0);

      // contact bounce: never stable long enough
      do_reset();
      for (int i = 0; i < 5; i++) begin
         fila = 4'b0100;
         step(3);
         fila = 4'd0;
         step(3);
      end
      chk("bounce_valid", 32'(key_valid), 32'h0);
      chk("bounce_code", 32'(key_code), 32'h0);

      // two presses on column 0 without ack -> overrun
      do_reset();
      fila = 4'b0001;
      step(10);
      chk("ov_valid1", 32'(key_valid), 32'h1);
      chk("ov_code1", 32'(key_code), 32'h0);
      fila = 4'd0;
      step(10);
      chk("ov_col_after_rel", 32'(columna), 32'h2);
      waited = 0;
      while (columna !== 4'b0001 && waited < 20) begin
         step(1);
         waited++;
      end
      chk("ov_wait_col0", 32'(columna), 32'h1);
      fila = 4'b0100;
      step(10);
      chk("ov_pulse", 32'(key_overrun), 32'h1);
      chk("ov_code_kept", 32'(key_code), 32'h0);
      chk("ov_valid_kept", 32'(key_valid), 32'h1);
      step(1);
      chk("ov_pulse_end", 32'(key_overrun), 32'h0);
      chk("ov_count", 32'(ovr_cnt), 32'h1);

      // acceptance coinciding with ack loads the new key (row 3, column 1 -> 13)
      fila = 4'd0;
      step(10);
      chk("co_col", 32'(columna), 32'h2);
      fila = 4'b1000;
      step(9);
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      chk("co_valid", 32'(key_valid), 32'h1);
      chk("co_code", 32'(key_code), 32'hd);
      chk("co_no_overrun", 32'(ovr_cnt), 32'h1);

      // multiple rows: no acceptance
      do_reset();
      fila = 4'b0101;
      step(20);
      chk("multi_valid", 32'(key_valid), 32'h0);
      chk("multi_code", 32'(key_code), 32'h0);

      // reset asserted mid-debounce aborts immediately
      do_reset();
      step(4);
      fila = 4'b0010;
      step(4);
      chk("abort_col_frozen", 32'(columna), 32'h2);
      rst = 1'b1;
      #1;
      chk("abort_col", 32'(columna), 32'h1);
      chk("abort_valid", 32'(key_valid), 32'h0);
      @(negedge clk);
      rst  = 1'b0;
      fila = 4'd0;
      step(12);
      chk("abort_no_key", 32'(key_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
